clz_denormalize: RTL and testbench

Iterative denormalizer: the inverse of the leading-zero-count normalizer. It accepts a left-justified value and its leading-zero count, and reconstructs the original value by right-shifting one barrel stage per cycle. It sits on the decode side of normalized datapaths, consuming normalized words plus counts through a valid/ready handshake and emitting the restored word through a second valid/ready handshake.

---
 rtl/clz_denormalize.sv | 98 +++++++++
 tb/tb_clz_denormalize.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clz_denormalize.sv
// Iterative denormalizer: restores a left-justified word from its leading-zero
// count by applying one right-shift barrel stage per cycle, MSB stage first.
module clz_denormalize #(
    parameter int W_IN  = 8,
    parameter int W_OUT = $clog2(W_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_data,
    input  logic [W_OUT-1:0] in_count,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_IN-1:0]  out_data,
    output logic             busy
);

    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the sender holds its payload until then.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [W_OUT-1:0] K_LAST = W_OUT'(W_OUT - 1);

    state_t           state_q, state_d;
    logic [W_IN-1:0]  shift_q, shift_d;
    logic [W_OUT-1:0] count_q, count_d;
    logic [W_OUT-1:0] k_q, k_d;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = shift_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    count_d = in_count;
                    // A zero word needs no shifting; its count is ambiguous anyway.
                    if (in_zero) begin
                        shift_d = '0;
                        state_d = DONE;
                    end else begin
                        shift_d = in_data;
                        k_d     = K_LAST;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                for (int i = 0; i < W_OUT; i++) begin
                    if (k_q == W_OUT'(i) && count_q[i]) begin
                        shift_d = shift_q >> (1 << i);
                    end
                end
                if (k_q == '0) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q - W_OUT'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: tb/tb_clz_denormalize.sv
// Bench for clz_denormalize: directed cases, backpressure, mid-flight reset,
// a full 8-bit sweep and random traffic, all checked through one scoreboard.
module tb_clz_denormalize;

    localparam int W_IN  = 8;
    localparam int W_OUT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W_IN-1:0]  in_data = '0;
    logic [W_OUT-1:0] in_count = '0;
    logic             in_zero = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W_IN-1:0]  out_data;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [W_IN-1:0] exp_q[$];
    int              lat_q[$];
    int              acc_q[$];

    logic            busy_exp   = 1'b0;
    logic            prev_valid = 1'b0;
    logic            prev_ready = 1'b0;
    logic [W_IN-1:0] prev_data  = '0;
    bit              rand_ready = 1'b0;

    clz_denormalize #(.W_IN(W_IN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: the original word is the normalized word divided by 2^count.
    function automatic logic [W_IN-1:0] ref_out(input logic [W_IN-1:0] d, input int c, input logic z);
        int v;
        v = int'(d);
        if (z) return '0;
        return W_IN'(v / (1 << c));
    endfunction

    function automatic int lead_zeros(input int x);
        int n;
        n = 0;
        if (x == 0) return W_IN - 1;
        while (x < (1 << (W_IN - 1 - n))) n++;
        return n;
    endfunction

    // Scoreboard monitor: records accepts, checks latency, data, busy and hold.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            lat_q.delete();
            acc_q.delete();
            busy_exp   = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            check("busy", 32'(busy), 32'(busy_exp));
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && !prev_valid) begin
                if (lat_q.size() == 0) check("unexpected_valid", 32'(out_valid), 32'd0);
                else check("latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    void'(lat_q.pop_front());
                    void'(acc_q.pop_front());
                end
                busy_exp = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_out(in_data, int'(in_count), in_zero));
                lat_q.push_back(in_zero ? 0 : W_OUT);
                acc_q.push_back(cyc + 1);
                busy_exp = 1'b1;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All driver tasks start and end just after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready2", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [W_IN-1:0] d, input logic [W_OUT-1:0] c, input logic z);
        int n;
        n = 0;
        in_data  = d;
        in_count = c;
        in_zero  = z;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = W_IN'($urandom_range(0, 255));
        in_count = W_OUT'($urandom_range(0, 7));
        in_zero  = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic [W_IN-1:0] d;
        #1;
        do_reset();
        out_ready = 1'b1;

        send(8'h98, 3'd3, 1'b0); drain();
        send(8'h80, 3'd0, 1'b0); drain();
        send(8'h80, 3'd7, 1'b0); drain();
        send(8'hFF, 3'd4, 1'b0); drain();
        send(8'h80, 3'd7, 1'b1); drain();

        // Backpressure with a competing request held at the input.
        out_ready = 1'b0;
        send(8'h98, 3'd3, 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        in_data  = 8'hC0;
        in_count = 3'd1;
        in_zero  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data", 32'(out_data), 32'h13);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset one cycle into SHIFT: the in-flight result must vanish.
        send(8'h98, 3'd3, 1'b0);
        @(posedge clk); #1;
        do_reset();
        repeat (6) @(posedge clk);
        #1;
        send(8'h98, 3'd3, 1'b0); drain();

        // Exhaustive round trip through normalization.
        for (int x = 0; x < 256; x++) begin
            n = lead_zeros(x);
            send(W_IN'(x << n), W_OUT'(n), x == 0);
        end
        drain();

        // Random traffic with random output backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            d = W_IN'($urandom_range(0, 255)) | 8'h80;
            send(d, W_OUT'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
